regfile_bypass: RTL



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_bypass.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the decode-stage register file.
//   WIDTH_DEFAULT / DEPTH_DEFAULT : default data width and register count
//   ZERO_REG                      : index of the hardwired-zero register
//   addr_width()                  : address width derived from the depth
package regfile_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT = 32;
  localparam int unsigned ZERO_REG      = 0;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register marks a destination still awaiting a load.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   we, waddr      write-back write; clears the pending bit of waddr
//   set_busy       load issued; marks set_addr pending (set wins over a same-cycle clear)
//   set_addr       destination of the issued load
//   raddr          flattened read addresses, port i at [i*AW +: AW]
//   bypass_clear   per port: this cycle's write forwards to that port, so it is not busy
//   busy           per port: the addressed register is pending
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic                set_busy,
  input  logic [AW-1:0]       set_addr,
  input  logic [NREAD*AW-1:0] raddr,
  input  logic [NREAD-1:0]    bypass_clear,
  output logic [NREAD-1:0]    busy
);

  logic [DEPTH-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (we) begin
      pend_d[waddr] = 1'b0;
    end
    // Applied after the clear so the newer load owns the register.
    if (set_busy) begin
      pend_d[set_addr] = 1'b1;
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_busy
    assign busy[g] = pend_q[raddr[g*AW +: AW]] & ~bypass_clear[g];
  end

endmodule

// File: rtl/regfile_bypass.sv
// Decode-stage register file: NREAD combinational read ports, one write port, optional
// same-cycle write-to-read forwarding and a pending-load scoreboard.
// Register 0 reads as zero, is never written and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward wdata to matching read ports in the
// write cycle (rhit driven, busy masked by the clearing write). Undefined: reads come from
// the array only and rhit is 0.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (clears array and scoreboard)
//   we, waddr, wdata  write port (WB stage)
//   ren               per-port read enable, only qualifies stall
//   raddr / rdata     flattened read addresses / data, port i at [i*AW +: AW] / [i*WIDTH +: WIDTH]
//   rhit              per port: data came from the bypass path
//   set_busy/set_addr mark a load destination pending
//   busy              per port: addressed register pending
//   stall             any enabled port reads a busy register
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       ren,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rhit,
  input  logic                   set_busy,
  input  logic [AW-1:0]          set_addr,
  output logic [NREAD-1:0]       busy,
  output logic                   stall
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [NREAD-1:0] hit;

  // Entry 0 is reset and never written, so it always reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != ZeroAddr)) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    logic [AW-1:0] ra;
    assign ra = raddr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign hit[g] = we && (waddr == ra) && (ra != ZeroAddr);
`else
    assign hit[g] = 1'b0;
`endif
    assign rdata[g*WIDTH +: WIDTH] = hit[g] ? wdata : mem_q[ra];
  end

  assign rhit = hit;

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .waddr        (waddr),
    .set_busy     (set_busy),
    .set_addr     (set_addr),
    .raddr        (raddr),
    .bypass_clear (hit),
    .busy         (busy)
  );

  assign stall = |(ren & busy);

endmodule
